// File: rtl/serial_sub.sv
// Bit-serial subtractor: computes a - b LSB first, one bit per clock, with a single
// borrow flip-flop; reports the difference, final borrow and signed overflow.
module serial_sub #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] d,
    output logic         bout,
    output logic         ovf
);

    localparam int CW = (W > 2) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   a_sh_q, a_sh_d;
    logic [W-1:0]   b_sh_q, b_sh_d;
    logic [W-1:0]   res_q, res_d;
    logic           br_q, br_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [W-1:0]   d_q, d_d;
    logic           bout_q, bout_d;
    logic           ovf_q, ovf_d;
    logic [1:0]     step_s;
    logic           diff_s;
    logic           br_nx_s;

    // Full-subtractor cell: returns {borrow_out, diff}.
    function automatic logic [1:0] sub_bit(input logic ai, input logic bi, input logic bri);
        logic di;
        logic bo;
        di = ai ^ bi ^ bri;
        bo = (~ai & bi) | (~(ai ^ bi) & bri);
        return {bo, di};
    endfunction

    assign step_s  = sub_bit(a_sh_q[0], b_sh_q[0], br_q);
    assign diff_s  = step_s[0];
    assign br_nx_s = step_s[1];

    assign busy = busy_q;
    assign done = done_q;
    assign d    = d_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;

    // Next-state and datapath control for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        d_d     = d_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_sh_d = {1'b0, a_sh_q[W-1:1]};
                b_sh_d = {1'b0, b_sh_q[W-1:1]};
                res_d  = {diff_s, res_q[W-1:1]};
                br_d   = br_nx_s;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    // Operand MSBs are still in bit 0 of the shifters on the last step.
                    d_d     = {diff_s, res_q[W-1:1]};
                    bout_d  = br_nx_s;
                    ovf_d   = (a_sh_q[0] != b_sh_q[0]) && (diff_s != a_sh_q[0]);
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    busy_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            d_q     <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            d_q     <= d_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule
